regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_if.sv | 42 ++++
 rtl/regfile_mp.sv | 117 +++++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// Signal bundle for the multi-port register file with scoreboard.
// Master drives addresses, writes and reserves; slave returns read data and status.
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]   ra;
    logic [NREAD*XLEN-1:0] rd;
    logic [NREAD-1:0]      busy;

    logic                  we_e;
    logic [AW-1:0]         wa_e;
    logic [XLEN-1:0]       wd_e;

    logic                  we_w;
    logic [AW-1:0]         wa_w;
    logic [XLEN-1:0]       wd_w;

    logic                  rsv_en;
    logic [AW-1:0]         rsv_a;

    logic [AW:0]           pend_cnt;

    modport master (
        output ra,
        output we_e, wa_e, wd_e,
        output we_w, wa_w, wd_w,
        output rsv_en, rsv_a,
        input  rd, busy, pend_cnt
    );

    modport slave (
        input  ra,
        input  we_e, wa_e, wd_e,
        input  we_w, wa_w, wd_w,
        input  rsv_en, rsv_a,
        output rd, busy, pend_cnt
    );
endinterface

// File: rtl/regfile_mp.sv
// Register file: NREAD read ports, Execute/Writeback write ports, pending scoreboard.
// Optional same-cycle write forwarding is enabled by REGFILE_MP_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    regfile_mp_if.slave    bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]       regs [NREGS];
    logic [NREGS-1:0]      pending;
    logic [AW:0]           cnt;

    logic                  wr_e;
    logic                  wr_w;
    logic                  clr_w;
    logic                  rsv_ok;
    logic [NREGS-1:0]      clr_mask;
    logic [NREGS-1:0]      set_mask;
    logic [NREGS-1:0]      pend_nxt;
    logic                  inc;
    logic                  dec_e;
    logic                  dec_w;
    logic [AW:0]           cnt_nxt;

    logic [NREAD*XLEN-1:0] rd_v;
    logic [NREAD-1:0]      busy_v;
    logic [AW-1:0]         a;
    logic                  hit_e;
    logic                  hit_w;

    // A Writeback colliding with Execute is dropped but still clears pending.
    assign wr_e   = reset_n && bus.we_e && (bus.wa_e != '0);
    assign clr_w  = reset_n && bus.we_w && (bus.wa_w != '0);
    assign wr_w   = clr_w && !(bus.we_e && (bus.wa_e == bus.wa_w));
    assign rsv_ok = reset_n && bus.rsv_en && (bus.rsv_a != '0);

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wr_e)
            clr_mask[bus.wa_e] = 1'b1;
        if (clr_w)
            clr_mask[bus.wa_w] = 1'b1;
        if (rsv_ok)
            set_mask[bus.rsv_a] = 1'b1;
    end

    assign pend_nxt = (pending & ~clr_mask) | set_mask;

    assign inc   = rsv_ok && !pending[bus.rsv_a];
    assign dec_e = wr_e && pending[bus.wa_e]
                   && !set_mask[bus.wa_e];
    assign dec_w = clr_w && !(wr_e && (bus.wa_e == bus.wa_w))
                   && pending[bus.wa_w]
                   && !set_mask[bus.wa_w];

    assign cnt_nxt = cnt
                   + {{AW{1'b0}}, inc}
                   - {{AW{1'b0}}, dec_e}
                   - {{AW{1'b0}}, dec_w};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
            pending <= '0;
            cnt     <= '0;
        end else begin
            if (wr_w)
                regs[bus.wa_w] <= bus.wd_w;
            if (wr_e)
                regs[bus.wa_e] <= bus.wd_e;
            pending <= pend_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        rd_v   = '0;
        busy_v = '0;
        a      = '0;
        hit_e  = 1'b0;
        hit_w  = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            a     = bus.ra[i*AW +: AW];
            hit_e = wr_e && (bus.wa_e == a);
            hit_w = clr_w && (bus.wa_w == a);
            if (a != '0) begin
                rd_v[i*XLEN +: XLEN] = regs[a];
                busy_v[i]            = pending[a];
            end
`ifdef REGFILE_MP_BYPASS_EN
            if (hit_e)
                rd_v[i*XLEN +: XLEN] = bus.wd_e;
            else if (hit_w)
                rd_v[i*XLEN +: XLEN] = bus.wd_w;
            if ((hit_e || hit_w) && !set_mask[a])
                busy_v[i] = 1'b0;
`endif
        end
    end

    assign bus.rd       = rd_v;
    assign bus.busy     = busy_v;
    assign bus.pend_cnt = cnt;

    a_cnt_pop: assert property (
        @(posedge clk) disable iff (!reset_n)
        cnt == AW'($countones(pending))
    );

endmodule
